reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of every architectural register.
REQ-002 Parameter NREG, default 32, register count; index width is log2(NREG) = 5.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rs1_addr  input  5  read port 1 register index.
REQ-007 rs2_addr  input  5  read port 2 register index.
REQ-008 rs1_data  output  32  read port 1 data, combinational.
REQ-009 rs2_data  output  32  read port 2 data, combinational.
REQ-010 we  input  1  writeback enable.
REQ-011 wr_addr  input  5  writeback register index.
REQ-012 wr_data  input  32  writeback data.
REQ-013 issue_valid  input  1  an instruction is issued this cycle and will write issue_rd.
REQ-014 issue_rd  input  5  destination index of the issued instruction.
REQ-015 rs1_busy  output  1  rs1 value not yet available; issue logic must stall.
REQ-016 rs2_busy  output  1  rs2 value not yet available; issue logic must stall.

Function
REQ-017 Storage SHALL be 31 XLEN-bit registers x1..x31; x0 SHALL read as 0 at all times.
REQ-018 On a rising edge with we=1 and wr_addr!=0, regs[wr_addr] SHALL take wr_data; writes to x0 SHALL be discarded.
REQ-019 rsN_data SHALL be zero-latency: 0 if rsN_addr=0; else wr_data if we=1 and wr_addr=rsN_addr (write-through bypass); else regs[rsN_addr].
REQ-020 Scoreboard: one pending bit per register; pending[0] SHALL be constant 0.
REQ-021 On a rising edge, issue_valid=1 and issue_rd!=0 SHALL set pending[issue_rd].
REQ-022 On a rising edge, we=1 and wr_addr!=0 SHALL clear pending[wr_addr].
REQ-023 Same-edge set and clear of the same index: set SHALL win (newer producer outstanding).
REQ-024 rsN_busy SHALL be pending[rsN_addr] AND NOT (we=1 and wr_addr=rsN_addr); always 0 for rsN_addr=0.
REQ-025 A write to a register with pending=0 SHALL update storage normally; no error is flagged.
REQ-026 Both read ports SHALL behave identically and independently, including when rs1_addr=rs2_addr.

Reset
REQ-027 rst=1 at a rising edge SHALL clear all registers to 0 and all pending bits to 0; it overrides a same-cycle we or issue_valid.
REQ-028 After reset, with no write in flight, rs1_data=rs2_data=0 and rs1_busy=rs2_busy=0 for every index.
REQ-029 Reset asserted mid-operation SHALL discard every outstanding pending bit; no writeback state survives.

Structure
REQ-030 XLEN, NREG, the register-index width and a reg_idx_t typedef SHALL live in the shared backend package.
REQ-031 Each read port SHALL instantiate the existing 32:1 32-bit select mux (mux32) over the storage array; bypass and x0 forcing sit after the mux.
REQ-032 The scoreboard SHALL be a flat 32-bit vector in the same module; no separate sub-module.

Verification
REQ-033 Reset, then read all 32 indices on both ports -> data 0, busy 0.
REQ-034 we=1, wr_addr=5, wr_data=32'hDEADBEEF, rs1_addr=5 in the same cycle -> rs1_data=DEADBEEF combinationally; next cycle, with we=0 -> still DEADBEEF.
REQ-035 we=1, wr_addr=0, wr_data=32'hFFFFFFFF -> rs1_addr=0 reads 0 in that cycle and afterwards.
REQ-036 issue_valid=1, issue_rd=7; next cycle rs2_addr=7 -> rs2_busy=1; then we=1, wr_addr=7, wr_data=32'h12 -> rs2_busy=0 and rs2_data=32'h12 in that cycle; pending[7] clear afterwards.
REQ-037 Same edge: issue_valid=1, issue_rd=9, we=1, wr_addr=9 -> pending[9] remains set; rs1_addr=9 reads busy=1 the next cycle.
REQ-038 Set pending[3] and pending[4], then assert rst=1 together with we=1, wr_addr=3 -> all pending bits 0 and x3=0 after the edge.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared backend package for the register file with scoreboard.
// Holds the architectural data width, register count, register-index
// width and the register-index type used by every port that names a
// register.
package reg_file_sb_pkg;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int IDX_W = $clog2(NREG);

   typedef logic [IDX_W-1:0] reg_idx_t;

endpackage : reg_file_sb_pkg

// File: rtl/reg_file_sb_mux32.sv
// mux32 -- 32:1 select mux, W bits wide.
// Ports:
//   din  : 32 packed W-bit inputs, indexed by sel
//   sel  : input index
//   dout : din[sel]
module mux32
   import reg_file_sb_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [31:0][W-1:0] din,
   input  reg_idx_t           sel,
   output logic [W-1:0]       dout
);

   assign dout = din[sel];

endmodule : mux32

// File: rtl/reg_file_sb.sv
// reg_file_sb -- 2-read / 1-write integer register file with a per-register
// pending-write scoreboard for in-order issue stall detection.
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   rs1_addr, rs2_addr  : read indices
//   rs1_data, rs2_data  : combinational read data (x0 = 0, write-through)
//   we, wr_addr, wr_data: writeback port
//   issue_valid,issue_rd: issued instruction that will later write issue_rd
//   rs1_busy, rs2_busy  : operand still outstanding, issue must stall
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int XLEN = reg_file_sb_pkg::XLEN,
   parameter int NREG = reg_file_sb_pkg::NREG
) (
   input  logic            clk,
   input  logic            rst,
   input  reg_idx_t        rs1_addr,
   input  reg_idx_t        rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            we,
   input  reg_idx_t        wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            issue_valid,
   input  reg_idx_t        issue_rd,
   output logic            rs1_busy,
   output logic            rs2_busy
);

   // Entry 0 is never written, so it stays 0 from reset onward; the read
   // path forces x0 to zero anyway, so nothing depends on that entry.
   logic [NREG-1:0][XLEN-1:0] regs;
   logic [NREG-1:0]           pending;

   logic            wr_ok;
   logic            issue_ok;
   logic [XLEN-1:0] rs1_raw;
   logic [XLEN-1:0] rs2_raw;
   logic            rs1_hit;
   logic            rs2_hit;

   assign wr_ok    = we && (wr_addr != '0);
   assign issue_ok = issue_valid && (issue_rd != '0);

   // NOTE: every state element uses non-blocking assignment, so all
   // updates take effect together after the edge regardless of statement
   // order -- except where two writes hit the same bit, where the later
   // statement wins (used below for set-over-clear).
   // NOTE: the storage is a flop array, not a RAM macro, and reset must
   // clear every architectural register, so it is reset explicitly.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs    <= '0;
         pending <= '0;
      end else begin
         if (wr_ok) begin
            regs[wr_addr]    <= wr_data;
            pending[wr_addr] <= 1'b0;
         end
         // Placed after the clear: a same-edge issue to the register being
         // written leaves it pending, since the newer producer is still
         // outstanding.
         if (issue_ok) begin
            pending[issue_rd] <= 1'b1;
         end
      end
   end

   mux32 #(.W(XLEN)) u_rs1_mux (
      .din  (regs),
      .sel  (rs1_addr),
      .dout (rs1_raw)
   );

   mux32 #(.W(XLEN)) u_rs2_mux (
      .din  (regs),
      .sel  (rs2_addr),
      .dout (rs2_raw)
   );

   // A write to x0 may still hit here, but the x0 forcing below has
   // priority, so the bypass never leaks a value onto x0.
   assign rs1_hit = we && (wr_addr == rs1_addr);
   assign rs2_hit = we && (wr_addr == rs2_addr);

   // NOTE: each output gets a default before the conditional overrides,
   // so no path through the block leaves it unassigned (no latch).
   always_comb begin
      rs1_data = rs1_raw;
      rs2_data = rs2_raw;
      if (rs1_hit)           rs1_data = wr_data;
      if (rs1_addr == '0)    rs1_data = '0;
      if (rs2_hit)           rs2_data = wr_data;
      if (rs2_addr == '0)    rs2_data = '0;
   end

   // pending[0] is never set, so x0 reads as not busy without a special case.
   assign rs1_busy = pending[rs1_addr] && !rs1_hit;
   assign rs2_busy = pending[rs2_addr] && !rs2_hit;

endmodule : reg_file_sb
